alu_seq: RTL
============

# alu_seq

Parametrised, handshaked successor to the datapath ALU of the 8-bit computer. It accepts one operation per transfer on a valid/ready input port and returns a registered result plus flags on a valid/ready output port. Single-cycle ops (add, sub, nand, branch-not-zero, set-less-than, shift) complete in one cycle. An iterative shift-add multiplier takes WIDTH cycles. The block sits between the instruction decoder (accumulator and register-file operands) and the writeback/PC-select logic.

## Interface
- WIDTH, 8: operand and result width; WIDTH ≥ 4.
- BR_W, 5: branch-target field width used by BNZ; BR_W ≤ WIDTH.
- CNT_W, $clog2(WIDTH): width of the multiply iteration counter.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request this cycle.
- in_op  in  3  opcode: 000 ADD, 001 NAND, 010 BNZ, 011 SLT, 100 SUB, 101 SHL, 110 MUL, 111 SHR.
- in_acc  in  WIDTH  accumulator operand (A).
- in_b  in  WIDTH  instruction-register operand (B).
- out_valid  out  1  result register holds an unconsumed result.
- out_ready  in  1  downstream accepts result.
- out_data  out  WIDTH  result.
- out_zero  out  1  out_data == 0.
- out_carry  out  1  carry/borrow/overflow flag (per op).
- out_neg  out  1  out_data[WIDTH-1].

## Operation
- Transfer in: in_valid && in_ready at a rising edge. Transfer out: out_valid && out_ready.
- in_ready = (state == IDLE) && (!out_valid || out_ready). The request is combinational on registered state and out_ready only.
- All arithmetic is unsigned modulo 2^WIDTH.
- ADD: A+B; carry = bit WIDTH of the (WIDTH+1)-bit sum.
- SUB: A−B; carry = borrow (A < B).
- NAND: ~(A&B); carry=0.
- BNZ: if A==0, result = B[BR_W-1:0] zero-extended; else result = 1; carry=0.
- SLT: result = (A < B) ? 1 : 0; carry=0.
- SHL: A<<1; carry = A[WIDTH-1]. SHR (logical): A>>1; carry = A[0].
- MUL: result = low WIDTH bits of A*B; carry = 1 if any high-half bit of the 2·WIDTH product is nonzero.
- State machine, two states:
  - IDLE: a non-MUL transfer loads the result/flags register and sets out_valid. A MUL transfer latches A into the multiplicand (2·WIDTH-bit) and B into the multiplier, clears the product, sets cnt=WIDTH-1, and enters MUL.
  - MUL: each cycle, if multiplier[0] then product += multiplicand; multiplicand <<= 1; multiplier >>= 1; cnt−−.
  - On the iteration where cnt==0, the final product is written to the output register, out_valid is set, and the state returns to IDLE.
- MUL completion stall: if cnt==0 while out_valid && !out_ready, the block holds in MUL with all multiplier state frozen until the output slot frees, then completes.
- Output register holds data/flags stable while out_valid && !out_ready.
- out_valid clears on an out transfer unless a new result loads in the same cycle. Load has priority, so back-to-back single-cycle ops stream at 1 per cycle.
- in_* are ignored when no input transfer occurs; the in_op/operand values seen at the transfer edge are the only ones used.

## Timing
- Reset: state=IDLE, out_valid=0, out_data=0, out_zero=0, out_carry=0, out_neg=0, cnt=0, product=0.
- in_ready is 1 in the first cycle after reset deasserts.
- Reset mid-MUL aborts the operation; no result is emitted.
- Single-cycle op latency: accept at edge E0, out_valid=1 after E0.
- MUL latency: accept at E0, iterations on E1..E_WIDTH, out_valid=1 after E_WIDTH (WIDTH cycles). in_ready=0 throughout MUL. Latency grows by one per stalled completion cycle.
- Simultaneous out transfer and new input transfer in the same cycle: the new result replaces the old, and out_valid stays 1.
- No combinational path from in_* to out_*.

## Test plan
- Reset then ADD A=8'hFF, B=8'h01 -> one cycle later out_data=8'h00, zero=1, carry=1, neg=0.
- SUB A=8'h03, B=8'h05 -> 8'hFE, carry=1, neg=1. NAND 8'hF0, 8'h3C -> 8'hCF.
- BNZ: A=0, B=8'hF7 -> 8'h17. BNZ: A=8'h02, B=8'hF7 -> 8'h01.
- SLT: 5 vs 9 -> 1; SLT: 9 vs 5 -> 0.
- MUL 13×11 -> 8'h8F, carry=0, out_valid exactly 8 cycles after accept, in_ready=0 during. MUL 16×16 -> 8'h00, zero=1, carry=1.
- Backpressure:
  - Hold out_ready=0 with 4 back-to-back ADDs offered: only the first is accepted, and out_data stays stable.
  - Release out_ready: the remaining ADDs stream at 1 result/cycle.
  - MUL completion while out_valid && !out_ready stalls without corrupting the product.
- Assert rst during MUL iteration 4 -> next cycle all outputs are at reset values and in_ready=1. A following ADD 2+3 returns 5.

Source files
------------

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked ALU with single-cycle ops and an iterative shift-add multiplier
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         operation request handshake
//   in_op, in_acc, in_b       opcode, accumulator operand (A), instruction operand (B)
//   out_valid/out_ready       result handshake
//   out_data                  registered result
//   out_zero/out_carry/out_neg registered flags

module alu_seq #(
    parameter int WIDTH = 8,
    parameter int BR_W  = 5,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_acc,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_carry,
    output logic             out_neg
);

    localparam logic S_IDLE = 1'b0;
    localparam logic S_MUL  = 1'b1;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_NAND = 3'b001;
    localparam logic [2:0] OP_BNZ  = 3'b010;
    localparam logic [2:0] OP_SLT  = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_SHL  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_SHR  = 3'b111;

    logic               state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic               out_zero_q, out_zero_d;
    logic               out_carry_q, out_carry_d;
    logic               out_neg_q, out_neg_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               in_fire;
    logic               out_fire;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] prod_step;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_carry;
    logic               load_en;
    logic [WIDTH-1:0]   load_data;
    logic               load_carry;

    assign in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;

    assign sum       = {1'b0, in_acc} + {1'b0, in_b};
    assign diff      = {1'b0, in_acc} - {1'b0, in_b};
    assign prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);

    // Single-cycle result path
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        case (in_op)
            OP_ADD: begin
                alu_res   = sum[WIDTH-1:0];
                alu_carry = sum[WIDTH];
            end
            OP_SUB: begin
                alu_res   = diff[WIDTH-1:0];
                alu_carry = diff[WIDTH];
            end
            OP_NAND: alu_res = ~(in_acc & in_b);
            OP_BNZ: begin
                if (in_acc == '0) begin
                    alu_res[BR_W-1:0] = in_b[BR_W-1:0];
                end else begin
                    alu_res = WIDTH'(1);
                end
            end
            OP_SLT: alu_res = (in_acc < in_b) ? WIDTH'(1) : '0;
            OP_SHL: begin
                alu_res   = {in_acc[WIDTH-2:0], 1'b0};
                alu_carry = in_acc[WIDTH-1];
            end
            OP_SHR: begin
                alu_res   = {1'b0, in_acc[WIDTH-1:1]};
                alu_carry = in_acc[0];
            end
            default: begin
                alu_res   = '0;
                alu_carry = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        prod_d     = prod_q;
        cnt_d      = cnt_q;
        load_en    = 1'b0;
        load_data  = alu_res;
        load_carry = alu_carry;

        case (state_q)
            S_IDLE: begin
                if (in_fire) begin
                    if (in_op == OP_MUL) begin
                        mcand_d  = {{WIDTH{1'b0}}, in_acc};
                        mplier_d = in_b;
                        prod_d   = '0;
                        cnt_d    = CNT_W'(WIDTH - 1);
                        state_d  = S_MUL;
                    end else begin
                        load_en = 1'b1;
                    end
                end
            end
            default: begin
                if (cnt_q != '0) begin
                    prod_d   = prod_step;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q - CNT_W'(1);
                end else if (!out_valid_q || out_ready) begin
                    // Final iteration: only commits once the output slot is free,
                    // otherwise everything stays frozen in place.
                    prod_d     = prod_step;
                    load_en    = 1'b1;
                    load_data  = prod_step[WIDTH-1:0];
                    load_carry = |prod_step[2*WIDTH-1:WIDTH];
                    state_d    = S_IDLE;
                end
            end
        endcase

        // A new load wins over a same-cycle drain so results stream back to back
        out_valid_d = out_valid_q && !out_fire;
        out_data_d  = out_data_q;
        out_zero_d  = out_zero_q;
        out_carry_d = out_carry_q;
        out_neg_d   = out_neg_q;
        if (load_en) begin
            out_valid_d = 1'b1;
            out_data_d  = load_data;
            out_zero_d  = (load_data == '0);
            out_carry_d = load_carry;
            out_neg_d   = load_data[WIDTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_zero_q  <= 1'b0;
            out_carry_q <= 1'b0;
            out_neg_q   <= 1'b0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            prod_q      <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_zero_q  <= out_zero_d;
            out_carry_q <= out_carry_d;
            out_neg_q   <= out_neg_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            prod_q      <= prod_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_zero  = out_zero_q;
    assign out_carry = out_carry_q;
    assign out_neg   = out_neg_q;

endmodule
